// File: rtl/host_link_codec.sv
// Byte-stuffing codec between the host arbiter's FIFO-style port and the transport FIFOs.
// TX escapes reserved bytes and inserts SYNC keepalives; RX strips escapes and tracks SYNC resync.
module host_link_codec #(
    parameter logic [7:0]  SYNC_BYTE = 8'h7E,
    parameter logic [7:0]  ESC_BYTE  = 8'h7D,
    parameter logic [7:0]  ESC_XOR   = 8'h20,
    parameter int unsigned KEEPALIVE = 0
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       arb_WREN,
    input  logic [7:0] arb_WRDATA,
    output logic       arb_WRFULL,
    input  logic       arb_RDEN,
    output logic [7:0] arb_RDDATA,
    output logic       arb_RDEMPTY,
    output logic       tx_WREN,
    output logic [7:0] tx_WRDATA,
    input  logic       tx_WRFULL,
    output logic       rx_RDEN,
    input  logic [7:0] rx_RDDATA,
    input  logic       rx_RDEMPTY,
    output logic       RESYNC,
    output logic [7:0] ERR_CNT
);

    localparam logic [23:0] KA_LIMIT = 24'(KEEPALIVE);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_PLAIN,
        TX_ESC2
    } tx_state_t;

    // ---------------- TX path ----------------
    tx_state_t   tx_state, tx_state_next;
    logic [7:0]  hold, hold_next;
    logic [23:0] ka_cnt, ka_next;
    logic        wrfull_next;
    logic        tx_wren_next;
    logic [7:0]  tx_wrdata_next;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        tx_state_next  = tx_state;
        hold_next      = hold;
        tx_wren_next   = 1'b0;
        tx_wrdata_next = tx_WRDATA;
        ka_next        = (ka_cnt < KA_LIMIT) ? ka_cnt + 24'd1 : ka_cnt;

        unique case (tx_state)
            TX_IDLE: begin
                // Keepalive may go out on the same edge a new byte lands in hold;
                // the byte then wins every later cycle because hold is no longer empty.
                if (arb_WREN) begin
                    hold_next     = arb_WRDATA;
                    tx_state_next = TX_PLAIN;
                end
                if (ka_cnt == KA_LIMIT && KA_LIMIT != 24'd0 && !tx_WRFULL) begin
                    tx_wren_next   = 1'b1;
                    tx_wrdata_next = SYNC_BYTE;
                end
            end
            TX_PLAIN: begin
                if (!tx_WRFULL) begin
                    tx_wren_next = 1'b1;
                    if (hold == SYNC_BYTE || hold == ESC_BYTE) begin
                        tx_wrdata_next = ESC_BYTE;
                        tx_state_next  = TX_ESC2;
                    end else begin
                        tx_wrdata_next = hold;
                        tx_state_next  = TX_IDLE;
                    end
                end
            end
            TX_ESC2: begin
                if (!tx_WRFULL) begin
                    tx_wren_next   = 1'b1;
                    tx_wrdata_next = hold ^ ESC_XOR;
                    tx_state_next  = TX_IDLE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase

        if (tx_wren_next) ka_next = 24'd0;
        wrfull_next = (tx_state_next != TX_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            tx_state   <= TX_IDLE;
            hold       <= 8'h00;
            ka_cnt     <= 24'd0;
            arb_WRFULL <= 1'b0;
            tx_WREN    <= 1'b0;
            tx_WRDATA  <= 8'h00;
        end else begin
            tx_state   <= tx_state_next;
            hold       <= hold_next;
            ka_cnt     <= ka_next;
            arb_WRFULL <= wrfull_next;
            tx_WREN    <= tx_wren_next;
            tx_WRDATA  <= tx_wrdata_next;
        end
    end

    // ---------------- RX path ----------------
    logic       rd_pend;            // transport byte arrives on rx_RDDATA this cycle
    logic       esc, esc_next;
    logic [7:0] rx_buf [2];
    logic [7:0] buf_next [2];
    logic [1:0] count, count_next;
    logic       push, pop, err_hit;
    logic [7:0] push_data;
    logic       resync_next, rden_next;
    logic [7:0] rdata_next, err_next;

    always_comb begin
        esc_next    = esc;
        resync_next = 1'b0;
        err_hit     = 1'b0;
        push        = 1'b0;
        push_data   = rx_RDDATA;

        if (rd_pend) begin
            if (rx_RDDATA == SYNC_BYTE) begin
                esc_next    = 1'b0;
                resync_next = 1'b1;
                err_hit     = esc;
            end else if (rx_RDDATA == ESC_BYTE) begin
                err_hit  = esc;
                esc_next = 1'b1;
            end else begin
                push      = 1'b1;
                push_data = esc ? (rx_RDDATA ^ ESC_XOR) : rx_RDDATA;
                esc_next  = 1'b0;
            end
        end

        pop        = arb_RDEN && !arb_RDEMPTY;
        buf_next   = rx_buf;
        count_next = count;
        if (pop) begin
            buf_next[0] = rx_buf[1];
            count_next  = count - 2'd1;
        end
        if (push) begin
            buf_next[count_next[0]] = push_data;
            count_next              = count_next + 2'd1;
        end

        rdata_next = pop ? rx_buf[0] : arb_RDDATA;
        // A new read only once the previous one has been decoded and the buffer has room.
        rden_next  = !rx_RDEMPTY && !rx_RDEN && (count_next < 2'd2);
        err_next   = (err_hit && ERR_CNT != 8'hFF) ? ERR_CNT + 8'd1 : ERR_CNT;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rx_RDEN     <= 1'b0;
            rd_pend     <= 1'b0;
            esc         <= 1'b0;
            // NOTE: the two buffer entries are reset so arb_RDDATA can never expose X after reset.
            rx_buf[0]   <= 8'h00;
            rx_buf[1]   <= 8'h00;
            count       <= 2'd0;
            arb_RDEMPTY <= 1'b1;
            arb_RDDATA  <= 8'h00;
            RESYNC      <= 1'b0;
            ERR_CNT     <= 8'h00;
        end else begin
            rx_RDEN     <= rden_next;
            rd_pend     <= rx_RDEN;
            esc         <= esc_next;
            rx_buf[0]   <= buf_next[0];
            rx_buf[1]   <= buf_next[1];
            count       <= count_next;
            arb_RDEMPTY <= (count_next == 2'd0);
            arb_RDDATA  <= rdata_next;
            RESYNC      <= resync_next;
            ERR_CNT     <= err_next;
        end
    end

endmodule

// File: tb/tb_host_link_codec.sv
// Scoreboard bench for host_link_codec: directed TX/RX vectors, transport RX FIFO model,
// decoupled monitors for the TX stream and the arbiter read side.
module tb_host_link_codec;

    logic       CLK = 1'b0;
    logic       RESETn = 1'b1;
    logic       arb_WREN = 1'b0;
    logic [7:0] arb_WRDATA = 8'h00;
    logic       arb_WRFULL;
    logic       arb_RDEN = 1'b0;
    logic [7:0] arb_RDDATA;
    logic       arb_RDEMPTY;
    logic       tx_WREN;
    logic [7:0] tx_WRDATA;
    logic       tx_WRFULL = 1'b0;
    logic       rx_RDEN;
    logic [7:0] rx_RDDATA = 8'h00;
    logic       rx_RDEMPTY = 1'b1;
    logic       RESYNC;
    logic [7:0] ERR_CNT;

    host_link_codec #(.KEEPALIVE(16)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .arb_WREN   (arb_WREN),
        .arb_WRDATA (arb_WRDATA),
        .arb_WRFULL (arb_WRFULL),
        .arb_RDEN   (arb_RDEN),
        .arb_RDDATA (arb_RDDATA),
        .arb_RDEMPTY(arb_RDEMPTY),
        .tx_WREN    (tx_WREN),
        .tx_WRDATA  (tx_WRDATA),
        .tx_WRFULL  (tx_WRFULL),
        .rx_RDEN    (rx_RDEN),
        .rx_RDDATA  (rx_RDDATA),
        .rx_RDEMPTY (rx_RDEMPTY),
        .RESYNC     (RESYNC),
        .ERR_CNT    (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tx_exp[$];   // expected non-SYNC transport bytes
    logic [7:0] rx_exp[$];   // expected decoded bytes at the arbiter
    logic [7:0] rx_q[$];     // contents of the modelled transport RX FIFO

    int cyc = 0, last_emit = 0, last_sync = 0;
    int gap_emit = 0, gap_sync = 0, sync_cnt = 0, resync_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    endtask

    // Transport RX FIFO: samples rx_RDEN at the edge, presents data just after it.
    initial begin
        forever begin
            logic en;
            @(negedge CLK);
            en = rx_RDEN;
            @(posedge CLK);
            #1;
            if (en) begin
                check("rx_read_nonempty", 32'(rx_q.size() != 0), 32'd1);
                if (rx_q.size() != 0) rx_RDDATA = rx_q.pop_front();
            end
            rx_RDEMPTY = (rx_q.size() == 0);
        end
    end

    // TX monitor: SYNCs are timed, everything else is scoreboarded.
    initial begin
        logic esc_follow = 1'b0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (esc_follow) check("esc_pair_consecutive", tx_WREN, 1'b1);
            esc_follow = 1'b0;
            if (RESYNC) resync_cnt++;
            if (tx_WREN) begin
                if (tx_WRDATA == 8'h7E) begin
                    sync_cnt++;
                    gap_emit  = cyc - last_emit;
                    gap_sync  = cyc - last_sync;
                    last_sync = cyc;
                end else if (tx_exp.size() == 0) begin
                    flag("tx_unexpected", $sformatf("emitted %0h with nothing expected", tx_WRDATA));
                end else begin
                    check("tx_stream", tx_WRDATA, tx_exp.pop_front());
                    if (tx_WRDATA == 8'h7D) esc_follow = 1'b1;
                end
                last_emit = cyc;
            end
        end
    end

    // Arbiter reader: pops whenever data is available, checks the byte one cycle later.
    initial begin
        forever begin
            @(negedge CLK);
            if (arb_RDEN) begin
                if (rx_exp.size() == 0) flag("rx_unexpected", $sformatf("read %0h with nothing expected", arb_RDDATA));
                else check("rx_data", arb_RDDATA, rx_exp.pop_front());
            end
            arb_RDEN = !arb_RDEMPTY;
        end
    end

    // One arbiter write; exp0/exp1 are the hand-encoded transport bytes.
    task automatic send(input logic [7:0] b, input logic [7:0] exp0, input logic [7:0] exp1,
                        input bit escaped, input bit check_latency);
        int n = 0;
        while (arb_WRFULL && n < 50) begin @(negedge CLK); n++; end
        if (arb_WRFULL) flag("send_timeout", "arb_WRFULL never cleared");
        tx_exp.push_back(exp0);
        if (escaped) tx_exp.push_back(exp1);
        arb_WREN   = 1'b1;
        arb_WRDATA = b;
        @(negedge CLK);
        arb_WREN = 1'b0;
        check("wrfull_after_accept", arb_WRFULL, 1'b1);
        if (check_latency) begin
            @(negedge CLK);
            check("tx_latency_wren", tx_WREN, 1'b1);
            check("tx_latency_data", tx_WRDATA, exp0);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((rx_q.size() != 0 || rx_exp.size() != 0 || tx_exp.size() != 0 ||
                arb_WRFULL || !arb_RDEMPTY) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) flag(name, "timed out waiting for idle");
        repeat (4) @(negedge CLK);
    endtask

    task automatic wait_sync();
        int s0 = sync_cnt;
        int n = 0;
        while (sync_cnt == s0 && n < 100) begin @(negedge CLK); #1; n++; end
        if (sync_cnt == s0) flag("keepalive_timeout", "no SYNC within 100 cycles");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_WREN"},     tx_WREN,     1'b0);
        check({tag, "_tx_WRDATA"},   tx_WRDATA,   8'h00);
        check({tag, "_rx_RDEN"},     rx_RDEN,     1'b0);
        check({tag, "_arb_WRFULL"},  arb_WRFULL,  1'b0);
        check({tag, "_arb_RDEMPTY"}, arb_RDEMPTY, 1'b1);
        check({tag, "_arb_RDDATA"},  arb_RDDATA,  8'h00);
        check({tag, "_RESYNC"},      RESYNC,      1'b0);
        check({tag, "_ERR_CNT"},     ERR_CNT,     8'h00);
    endtask

    initial begin
        int r0;
        int stalled;
        int n;

        #1 RESETn = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);

        // Reset mid-operation: stalled escape in hold, ERR_CNT nonzero, esc set.
        tx_WRFULL = 1'b1;
        send(8'h7E, 8'h7D, 8'h5E, 1'b1, 1'b0);
        rx_q.push_back(8'h7D); rx_q.push_back(8'h7D); rx_q.push_back(8'h7D);
        n = 0;
        while (rx_q.size() != 0 && n < 100) begin @(negedge CLK); n++; end
        repeat (4) @(negedge CLK);
        check("pre_reset_err_cnt", ERR_CNT, 8'd2);
        check("pre_reset_wrfull", arb_WRFULL, 1'b1);
        #2 RESETn = 1'b0;
        #1 check_reset_outputs("midop");
        tx_exp.delete();
        repeat (2) @(negedge CLK);
        RESETn    = 1'b1;
        tx_WRFULL = 1'b0;
        repeat (5) @(negedge CLK);
        check("post_reset_wrfull", arb_WRFULL, 1'b0);
        check("post_reset_rdempty", arb_RDEMPTY, 1'b1);
        check("post_reset_err_cnt", ERR_CNT, 8'h00);
        rx_q.push_back(8'h61);
        rx_exp.push_back(8'h61);     // esc was cleared by reset, so no XOR
        wait_idle("post_reset_idle");

        // TX escaping: 41, 7E, 7D -> 41, 7D 5E, 7D 5D
        send(8'h41, 8'h41, 8'h00, 1'b0, 1'b1);
        send(8'h7E, 8'h7D, 8'h5E, 1'b1, 1'b1);
        send(8'h7D, 8'h7D, 8'h5D, 1'b1, 1'b1);
        wait_idle("tx_escape_idle");

        // TX backpressure on a held 7E
        tx_WRFULL = 1'b1;
        send(8'h7E, 8'h7D, 8'h5E, 1'b1, 1'b0);
        stalled = 0;
        repeat (20) begin
            @(negedge CLK);
            if (tx_WREN) stalled++;
        end
        check("stall_no_emit", stalled, 0);
        tx_WRFULL = 1'b0;
        @(negedge CLK);
        check("release_wren", tx_WREN, 1'b1);
        check("release_data", tx_WRDATA, 8'h7D);
        wait_idle("backpressure_idle");

        // RX decode
        r0 = resync_cnt;
        rx_q.push_back(8'h41); rx_q.push_back(8'h7D); rx_q.push_back(8'h5E);
        rx_q.push_back(8'h7D); rx_q.push_back(8'h5D); rx_q.push_back(8'h7E);
        rx_exp.push_back(8'h41); rx_exp.push_back(8'h7E); rx_exp.push_back(8'h7D);
        wait_idle("rx_decode_idle");
        check("rx_decode_resync", resync_cnt - r0, 1);
        check("rx_decode_err_cnt", ERR_CNT, 8'h00);

        // RX errors: ESC+SYNC and ESC+ESC
        r0 = resync_cnt;
        rx_q.push_back(8'h7D); rx_q.push_back(8'h7E); rx_q.push_back(8'h7D);
        rx_q.push_back(8'h7D); rx_q.push_back(8'h61);
        rx_exp.push_back(8'h41);
        wait_idle("rx_err_idle");
        check("rx_err_resync", resync_cnt - r0, 1);
        check("rx_err_cnt", ERR_CNT, 8'd2);

        // Saturation: 1 ESC arms esc, then 252 errors -> FE; 48 more -> 300 total, pinned at FF
        for (int i = 0; i < 253; i++) rx_q.push_back(8'h7D);
        wait_idle("sat_idle_a");
        check("err_cnt_fe", ERR_CNT, 8'hFE);
        for (int i = 0; i < 48; i++) rx_q.push_back(8'h7D);
        wait_idle("sat_idle_b");
        check("err_cnt_sat", ERR_CNT, 8'hFF);
        r0 = resync_cnt;
        rx_q.push_back(8'h7E); rx_q.push_back(8'h61);
        rx_exp.push_back(8'h61);
        wait_idle("sat_idle_c");
        check("err_cnt_stays_sat", ERR_CNT, 8'hFF);
        check("sat_resync", resync_cnt - r0, 1);

        // Keepalive: SYNC every 17 cycles while idle
        repeat (3) begin
            wait_sync();
            check("keepalive_gap", gap_emit, 17);
        end
        repeat (5) @(negedge CLK);
        send(8'h55, 8'h55, 8'h00, 1'b0, 1'b1);
        wait_sync();
        check("keepalive_after_data", gap_emit, 17);
        check("keepalive_delayed", gap_sync, 24);

        wait_idle("final_idle");
        check("tx_queue_drained", tx_exp.size(), 0);
        check("rx_queue_drained", rx_exp.size(), 0);
        summary();
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        n_errors++;
        summary();
        $fatal(1, "watchdog expired");
    end

endmodule
